rtc_display_sequencer: RTL and testbench



---
 rtl/rtc_disp_pkg.sv | 54 +++++
 rtl/rtc_alarm_latch.sv | 32 +++
 rtl/rtc_display_sequencer.sv | 149 ++++++++++++++
 tb/tb_rtc_display_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_disp_pkg.sv
// Shared constants for the RTC display sequencer: register addresses,
// sweep index ordering and FSM state encoding.
package rtc_disp_pkg;

  localparam int NUM_REGS = 9;

  localparam logic [7:0] ADDR_SEG        = 8'h21;
  localparam logic [7:0] ADDR_MIN        = 8'h22;
  localparam logic [7:0] ADDR_HORA       = 8'h23;
  localparam logic [7:0] ADDR_DIA        = 8'h24;
  localparam logic [7:0] ADDR_MES        = 8'h25;
  localparam logic [7:0] ADDR_YEAR       = 8'h26;
  localparam logic [7:0] ADDR_SEG_TIMER  = 8'h41;
  localparam logic [7:0] ADDR_MIN_TIMER  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIMER = 8'h43;

  localparam logic [3:0] IDX_SEG        = 4'd0;
  localparam logic [3:0] IDX_MIN        = 4'd1;
  localparam logic [3:0] IDX_HORA       = 4'd2;
  localparam logic [3:0] IDX_DIA        = 4'd3;
  localparam logic [3:0] IDX_MES        = 4'd4;
  localparam logic [3:0] IDX_YEAR       = 4'd5;
  localparam logic [3:0] IDX_SEG_TIMER  = 4'd6;
  localparam logic [3:0] IDX_MIN_TIMER  = 4'd7;
  localparam logic [3:0] IDX_HORA_TIMER = 4'd8;
  localparam logic [3:0] IDX_LAST       = IDX_HORA_TIMER;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_GAP    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Maps a sweep index to its RTC register address.
  function automatic logic [7:0] addr_of(input logic [3:0] idx);
    logic [7:0] a;
    a = 8'h00;
    case (idx)
      IDX_SEG:        a = ADDR_SEG;
      IDX_MIN:        a = ADDR_MIN;
      IDX_HORA:       a = ADDR_HORA;
      IDX_DIA:        a = ADDR_DIA;
      IDX_MES:        a = ADDR_MES;
      IDX_YEAR:       a = ADDR_YEAR;
      IDX_SEG_TIMER:  a = ADDR_SEG_TIMER;
      IDX_MIN_TIMER:  a = ADDR_MIN_TIMER;
      IDX_HORA_TIMER: a = ADDR_HORA_TIMER;
      default:        a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_alarm_latch.sv
// Alarm latch: sets on a committed zero-crossing of the countdown timer,
// clears on the alarm key; a set in the same cycle as a clear wins.
module rtc_alarm_latch #(
  parameter logic [7:0] ALARM_KEY = 8'h21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       commit,
  input  logic       old_timer_zero,
  input  logic       new_timer_zero,
  input  logic [7:0] tecla,
  input  logic       tecla_valid,
  output logic       alarm_ring
);

  logic set_alarm;
  logic clear_alarm;

  assign set_alarm   = commit && new_timer_zero && !old_timer_zero;
  assign clear_alarm = tecla_valid && (tecla == ALARM_KEY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_ring <= 1'b0;
    end else if (set_alarm) begin
      alarm_ring <= 1'b1;
    end else if (clear_alarm) begin
      alarm_ring <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_display_sequencer.sv
// Sweeps the nine RTC registers into shadow storage and commits them to the
// overlay outputs on a single edge, so the display never shows a torn time.
module rtc_display_sequencer
  import rtc_disp_pkg::*;
#(
  parameter int         REFRESH_FRAMES = 1,
  parameter int         ACK_TIMEOUT    = 255,
  parameter logic [7:0] ALARM_KEY      = 8'h21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  input  logic [7:0] tecla,
  input  logic       tecla_valid,
  output logic [7:0] seg_reg,
  output logic [7:0] min_reg,
  output logic [7:0] hora_reg,
  output logic [7:0] dia_reg,
  output logic [7:0] mes_reg,
  output logic [7:0] year_reg,
  output logic [7:0] seg_timer_reg,
  output logic [7:0] min_timer_reg,
  output logic [7:0] hora_timer_reg,
  output logic       alarm_ring,
  output logic       busy,
  output logic       err_timeout
);

  localparam logic [7:0] REFRESH_LAST = 8'(REFRESH_FRAMES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic [7:0] frame_cnt;
  logic [7:0] tmo_cnt;
  logic [3:0] idx;
  logic [7:0] shadow [NUM_REGS];

  logic commit;
  logic old_timer_zero;
  logic new_timer_zero;

  assign commit         = (state == ST_COMMIT);
  assign old_timer_zero = (seg_timer_reg == 8'h00) && (min_timer_reg == 8'h00) &&
                          (hora_timer_reg == 8'h00);
  assign new_timer_zero = (shadow[IDX_SEG_TIMER] == 8'h00) &&
                          (shadow[IDX_MIN_TIMER] == 8'h00) &&
                          (shadow[IDX_HORA_TIMER] == 8'h00);

  // rd_req is high exactly in REQ, so an ack outside REQ never lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      frame_cnt      <= 8'h00;
      tmo_cnt        <= 8'h00;
      idx            <= 4'd0;
      rd_req         <= 1'b0;
      rd_addr        <= 8'h00;
      busy           <= 1'b0;
      err_timeout    <= 1'b0;
      seg_reg        <= 8'h00;
      min_reg        <= 8'h00;
      hora_reg       <= 8'h00;
      dia_reg        <= 8'h00;
      mes_reg        <= 8'h00;
      year_reg       <= 8'h00;
      seg_timer_reg  <= 8'h00;
      min_timer_reg  <= 8'h00;
      hora_timer_reg <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            if (frame_cnt == REFRESH_LAST) begin
              frame_cnt <= 8'h00;
              idx       <= 4'd0;
              tmo_cnt   <= 8'h00;
              rd_req    <= 1'b1;
              rd_addr   <= addr_of(4'd0);
              busy      <= 1'b1;
              state     <= ST_REQ;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            shadow[idx] <= rd_data;
            rd_req      <= 1'b0;
            state       <= ST_GAP;
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            // Abandon the sweep; committed outputs keep their last values.
            err_timeout <= 1'b1;
            rd_req      <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'h00;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (idx == IDX_LAST) begin
            state <= ST_COMMIT;
          end else begin
            idx     <= idx + 4'd1;
            tmo_cnt <= 8'h00;
            rd_req  <= 1'b1;
            rd_addr <= addr_of(idx + 4'd1);
            state   <= ST_REQ;
          end
        end
        ST_COMMIT: begin
          seg_reg        <= shadow[IDX_SEG];
          min_reg        <= shadow[IDX_MIN];
          hora_reg       <= shadow[IDX_HORA];
          dia_reg        <= shadow[IDX_DIA];
          mes_reg        <= shadow[IDX_MES];
          year_reg       <= shadow[IDX_YEAR];
          seg_timer_reg  <= shadow[IDX_SEG_TIMER];
          min_timer_reg  <= shadow[IDX_MIN_TIMER];
          hora_timer_reg <= shadow[IDX_HORA_TIMER];
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rtc_alarm_latch #(
    .ALARM_KEY(ALARM_KEY)
  ) u_alarm (
    .clk           (clk),
    .reset_n       (reset_n),
    .commit        (commit),
    .old_timer_zero(old_timer_zero),
    .new_timer_zero(new_timer_zero),
    .tecla         (tecla),
    .tecla_valid   (tecla_valid),
    .alarm_ring    (alarm_ring)
  );

endmodule

// File: tb/tb_rtc_display_sequencer.sv
// Directed bench for rtc_display_sequencer: bus model, address/commit
// scoreboards, timeout, alarm, divider and asynchronous reset scenarios.
module tb_rtc_display_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] tecla = 8'h00;
  logic       tecla_valid = 1'b0;
  logic [7:0] seg_reg, min_reg, hora_reg, dia_reg, mes_reg, year_reg;
  logic [7:0] seg_timer_reg, min_timer_reg, hora_timer_reg;
  logic       alarm_ring, busy, err_timeout;

  logic       frame_tick_b = 1'b0;
  logic       rd_req_b;
  logic [7:0] rd_addr_b;
  logic       rd_ack_b;
  logic [7:0] rd_data_b;
  logic [7:0] seg_b, min_b, hora_b, dia_b, mes_b, year_b;
  logic [7:0] seg_t_b, min_t_b, hora_t_b;
  logic       alarm_b, busy_b, err_b;

  int checks = 0;
  int errors = 0;

  int         req_lat = 1;
  int         req_cnt = 0;
  logic [7:0] nack_addr = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                8'h41, 8'h42, 8'h43};
  logic [7:0]  addr_q [$];
  logic [71:0] val_q [$];
  logic [71:0] exp_out = 72'h0;
  logic        prev_req = 1'b0;
  int          sweeps_b = 0;

  always #5 clk = ~clk;

  rtc_display_sequencer #(
    .REFRESH_FRAMES(1), .ACK_TIMEOUT(8), .ALARM_KEY(8'h21)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .tecla(tecla), .tecla_valid(tecla_valid),
    .seg_reg(seg_reg), .min_reg(min_reg), .hora_reg(hora_reg),
    .dia_reg(dia_reg), .mes_reg(mes_reg), .year_reg(year_reg),
    .seg_timer_reg(seg_timer_reg), .min_timer_reg(min_timer_reg),
    .hora_timer_reg(hora_timer_reg),
    .alarm_ring(alarm_ring), .busy(busy), .err_timeout(err_timeout)
  );

  // Second instance exercises the frame divider; it acks in the first REQ cycle.
  assign rd_ack_b  = rd_req_b;
  assign rd_data_b = rd_addr_b + 8'h30;

  rtc_display_sequencer #(
    .REFRESH_FRAMES(3), .ACK_TIMEOUT(8), .ALARM_KEY(8'h21)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_ack(rd_ack_b), .rd_data(rd_data_b),
    .tecla(tecla), .tecla_valid(tecla_valid),
    .seg_reg(seg_b), .min_reg(min_b), .hora_reg(hora_b),
    .dia_reg(dia_b), .mes_reg(mes_b), .year_reg(year_b),
    .seg_timer_reg(seg_t_b), .min_timer_reg(min_t_b), .hora_timer_reg(hora_t_b),
    .alarm_ring(alarm_b), .busy(busy_b), .err_timeout(err_b)
  );

  task automatic check_output(input string tag, input logic [71:0] obs,
                              input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] outs();
    return {seg_reg, min_reg, hora_reg, dia_reg, mes_reg, year_reg,
            seg_timer_reg, min_timer_reg, hora_timer_reg};
  endfunction

  function automatic logic [71:0] model_vals();
    logic [71:0] v;
    v = 72'h0;
    for (int i = 0; i < 9; i++) v = {v[63:0], mem[addr_tab[i]]};
    return v;
  endfunction

  task automatic set_regs(input logic [71:0] v);
    for (int i = 0; i < 9; i++) mem[addr_tab[i]] = v[71 - 8*i -: 8];
  endtask

  // RTC bus model: acks on the req_lat-th REQ cycle, never for nack_addr.
  always @(negedge clk) begin
    if (!reset_n || !rd_req) begin
      req_cnt = 0;
      rd_ack  = 1'b0;
    end else begin
      req_cnt++;
      if (req_cnt == req_lat && rd_addr != nack_addr) begin
        rd_ack  = 1'b1;
        rd_data = mem[rd_addr];
      end else begin
        rd_ack  = 1'b0;
        rd_data = 8'hEE;
      end
    end
  end

  // Address scoreboard: each rising rd_req consumes one expected address.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rd_req && !prev_req) begin
      e = (addr_q.size() > 0) ? addr_q.pop_front() : 8'hxx;
      check_output("rd_addr_seq", {64'h0, rd_addr}, {64'h0, e});
    end
    prev_req = rd_req;
  end

  always @(posedge busy_b) sweeps_b++;

  task automatic run_sweep(input int lat, input logic [7:0] nack,
                           input bit key_at_commit, input int exp_busy,
                           input logic exp_alarm, input string tag);
    int n;
    bit torn;
    req_lat   = lat;
    nack_addr = nack;
    for (int i = 0; i < 9; i++) begin
      addr_q.push_back(addr_tab[i]);
      if (addr_tab[i] == nack) break;
    end
    if (nack == 8'h00) val_q.push_back(model_vals());
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    torn = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (outs() !== exp_out) torn = 1'b1;
      if (key_at_commit) begin
        tecla       = (n == exp_busy - 1) ? 8'h21 : 8'h00;
        tecla_valid = (n == exp_busy - 1);
      end
      n++;
      @(negedge clk);
    end
    tecla_valid = 1'b0;
    tecla       = 8'h00;
    check_output({tag, "_busy_cycles"}, 72'(n), 72'(exp_busy));
    check_output({tag, "_atomic"}, {71'h0, torn}, 72'h0);
    if (nack == 8'h00 && val_q.size() > 0) exp_out = val_q.pop_front();
    check_output({tag, "_values"}, outs(), exp_out);
    check_output({tag, "_alarm"}, {71'h0, alarm_ring}, {71'h0, exp_alarm});
    check_output({tag, "_addr_drained"}, 72'(addr_q.size()), 72'h0);
  endtask

  task automatic apply_key(input logic [7:0] code);
    tecla       = code;
    tecla_valid = 1'b1;
    @(negedge clk);
    tecla_valid = 1'b0;
    tecla       = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    check_output("reset_values", outs(), 72'h0);
    check_output("reset_rd_req", {71'h0, rd_req}, 72'h0);
    check_output("reset_rd_addr", {64'h0, rd_addr}, 72'h0);
    check_output("reset_busy", {71'h0, busy}, 72'h0);
    check_output("reset_alarm", {71'h0, alarm_ring}, 72'h0);
    check_output("reset_err", {71'h0, err_timeout}, 72'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] full sweep, latency 2");
    set_regs(72'h10_11_12_13_14_15_16_17_18);
    run_sweep(2, 8'h00, 1'b0, 28, 1'b0, "sweep_l2");
    check_output("err_after_good", {71'h0, err_timeout}, 72'h0);

    $display("[TB] timeout on mes");
    set_regs(72'h60_61_62_63_64_65_66_67_68);
    run_sweep(2, 8'h25, 1'b0, 20, 1'b0, "timeout");
    check_output("err_set", {71'h0, err_timeout}, 72'h1);
    repeat (2) @(negedge clk);

    $display("[TB] fresh sweep, timer 00:00:01");
    set_regs(72'h30_31_32_33_34_35_01_00_00);
    run_sweep(3, 8'h00, 1'b0, 37, 1'b0, "sweep_l3");
    check_output("err_sticky", {71'h0, err_timeout}, 72'h1);

    $display("[TB] alarm set and clear");
    set_regs(72'h45_44_12_01_02_26_00_00_00);
    run_sweep(1, 8'h00, 1'b0, 19, 1'b1, "zero_cross");
    apply_key(8'h20);
    check_output("wrong_key_keeps", {71'h0, alarm_ring}, 72'h1);
    apply_key(8'h21);
    check_output("key_clears", {71'h0, alarm_ring}, 72'h0);
    set_regs(72'h46_44_12_01_02_26_00_00_00);
    run_sweep(1, 8'h00, 1'b0, 19, 1'b0, "zero_again");
    set_regs(72'h47_44_12_01_02_26_00_59_00);
    run_sweep(1, 8'h00, 1'b0, 19, 1'b0, "nonzero");
    set_regs(72'h48_44_12_01_02_26_00_00_00);
    run_sweep(1, 8'h00, 1'b1, 19, 1'b1, "collision");
    @(negedge clk);
    check_output("collision_hold", {71'h0, alarm_ring}, 72'h1);

    $display("[TB] frame divider");
    for (int t = 1; t <= 6; t++) begin
      frame_tick_b = 1'b1;
      @(negedge clk);
      frame_tick_b = 1'b0;
      repeat (25) @(negedge clk);
      if (t == 2) check_output("div_after_2", 72'(sweeps_b), 72'h0);
      if (t == 3) check_output("div_after_3", 72'(sweeps_b), 72'h1);
    end
    check_output("div_after_6", 72'(sweeps_b), 72'h2);
    check_output("div_values",
                 {seg_b, min_b, hora_b, dia_b, mes_b, year_b, seg_t_b, min_t_b, hora_t_b},
                 72'h51_52_53_54_55_56_71_72_73);
    check_output("div_flags", {69'h0, alarm_b, err_b, busy_b}, 72'h0);

    $display("[TB] reset during REQ");
    req_lat   = 3;
    nack_addr = 8'h00;
    addr_q.push_back(8'h21);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check_output("pre_reset_req", {71'h0, rd_req}, 72'h1);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_rd_req", {71'h0, rd_req}, 72'h0);
    check_output("async_values", outs(), 72'h0);
    check_output("async_flags", {69'h0, alarm_ring, err_timeout, busy}, 72'h0);
    check_output("async_rd_addr", {64'h0, rd_addr}, 72'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("idle_after_reset", {70'h0, rd_req, busy}, 72'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
